// File: rtl/serial_fifo_link.sv
// serial_fifo_link: MSB-first serial deserializer feeding a DEPTH-entry word queue, all on clock_1MHz.
// Optional macro SFL_DROP_EN: a held word is discarded (and counted on drop_cnt) when the queue is full on a queue tick.
module serial_fifo_link #(
  parameter int WIDTH   = 8,
  parameter int DEPTH   = 8,
  parameter int DES_DIV = 10,
  parameter int Q_DIV   = 100
) (
  input  logic                       clock_1MHz,
  input  logic                       rst,
  input  logic                       data_in,
  input  logic                       write_in,
  input  logic                       dequeue_in,
  output logic                       status_out,
  output logic                       word_ack,
  output logic [WIDTH-1:0]           data_out,
  output logic [$clog2(DEPTH+1)-1:0] len_out,
  output logic                       full_out,
  output logic                       empty_out
`ifdef SFL_DROP_EN
  ,
  output logic [7:0]                 drop_cnt
`endif
);

  localparam int LW  = $clog2(DEPTH+1);
  localparam int PW  = $clog2(DEPTH);
  localparam int CW  = $clog2(WIDTH+1);
  localparam int DCW = $clog2(DES_DIV);
  localparam int QCW = $clog2(Q_DIV);

  typedef enum logic {COLLECT, HOLD} state_t;

  state_t           state, state_nxt;
  logic [DCW-1:0]   des_cnt;
  logic [QCW-1:0]   q_cnt;
  logic             des_tick, q_tick;
  logic [WIDTH-1:0] shift_reg, shift_nxt, hold_word;
  logic [CW-1:0]    bit_cnt;
  logic             bit_shift, bit_done;
  logic             push, pop, drop;
  logic [WIDTH-1:0] mem [DEPTH];
  logic [PW-1:0]    head, tail;
  logic [LW-1:0]    len_nxt;

  // Tick generation: free-running dividers, one-cycle enables, no derived clocks
  always_ff @(posedge clock_1MHz or posedge rst) begin
    if (rst) begin
      des_cnt <= '0;
      q_cnt   <= '0;
    end else begin
      des_cnt <= des_tick ? '0 : des_cnt + 1'b1;
      q_cnt   <= q_tick   ? '0 : q_cnt + 1'b1;
    end
  end

  assign des_tick = (des_cnt == DCW'(DES_DIV-1));
  assign q_tick   = (q_cnt == QCW'(Q_DIV-1));

  assign status_out = (state == COLLECT);
  assign bit_shift  = (state == COLLECT) && des_tick && write_in;
  assign bit_done   = bit_shift && (bit_cnt == CW'(WIDTH-1));
  assign shift_nxt  = {shift_reg[WIDTH-2:0], data_in};

  // A pop that tick frees the slot a full queue needs for the held word
  assign pop  = q_tick && dequeue_in && !empty_out;
  assign push = (state == HOLD) && q_tick && (!full_out || pop);
`ifdef SFL_DROP_EN
  assign drop = (state == HOLD) && q_tick && full_out && !pop;
`else
  assign drop = 1'b0;
`endif

  always_ff @(posedge clock_1MHz or posedge rst) begin
    if (rst) state <= COLLECT;
    else     state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      COLLECT: if (bit_done)      state_nxt = HOLD;
      HOLD:    if (push || drop)  state_nxt = COLLECT;
      default:                    state_nxt = COLLECT;
    endcase
  end

  // Deserializer datapath
  always_ff @(posedge clock_1MHz or posedge rst) begin
    if (rst) begin
      shift_reg <= '0;
      bit_cnt   <= '0;
      hold_word <= '0;
    end else if (bit_shift) begin
      shift_reg <= shift_nxt;
      if (bit_done) begin
        hold_word <= shift_nxt;
        bit_cnt   <= '0;
      end else begin
        bit_cnt   <= bit_cnt + 1'b1;
      end
    end
  end

  always_comb begin
    len_nxt = len_out;
    case ({push, pop})
      2'b10:   len_nxt = len_out + 1'b1;
      2'b01:   len_nxt = len_out - 1'b1;
      default: len_nxt = len_out;
    endcase
  end

  // Queue: pointers wrap naturally because DEPTH is a power of two
  always_ff @(posedge clock_1MHz or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < DEPTH; i++) mem[i] <= '0;
      head      <= '0;
      tail      <= '0;
      data_out  <= '0;
      word_ack  <= 1'b0;
      len_out   <= '0;
      full_out  <= 1'b0;
      empty_out <= 1'b1;
    end else begin
      word_ack <= push;
      if (push) begin
        mem[tail] <= hold_word;
        tail      <= tail + 1'b1;
      end
      if (pop) begin
        data_out <= mem[head];
        head     <= head + 1'b1;
      end
      len_out   <= len_nxt;
      full_out  <= (len_nxt == LW'(DEPTH));
      empty_out <= (len_nxt == '0);
    end
  end

`ifdef SFL_DROP_EN
  always_ff @(posedge clock_1MHz or posedge rst) begin
    if (rst)                            drop_cnt <= 8'd0;
    else if (drop && drop_cnt != 8'hFF) drop_cnt <= drop_cnt + 8'd1;
  end
`endif

endmodule

// File: tb/tb_serial_fifo_link.sv
// Directed self-checking bench for serial_fifo_link; follows SFL_DROP_EN when it is defined.
module tb_serial_fifo_link;
  localparam int WIDTH = 8, DEPTH = 8, DES_DIV = 10, Q_DIV = 100;
  localparam int LW = $clog2(DEPTH+1);

  logic clock_1MHz = 1'b0;
  logic rst;
  logic data_in = 1'b0, write_in = 1'b0, dequeue_in = 1'b0;
  logic status_out, word_ack, full_out, empty_out;
  logic [WIDTH-1:0] data_out;
  logic [LW-1:0] len_out;
`ifdef SFL_DROP_EN
  logic [7:0] drop_cnt;
`endif

  int errors = 0, checks = 0;
  int des_cnt, q_cnt;

  serial_fifo_link #(.WIDTH(WIDTH), .DEPTH(DEPTH), .DES_DIV(DES_DIV), .Q_DIV(Q_DIV)) dut (
    .clock_1MHz(clock_1MHz), .rst(rst), .data_in(data_in), .write_in(write_in),
    .dequeue_in(dequeue_in), .status_out(status_out), .word_ack(word_ack),
    .data_out(data_out), .len_out(len_out), .full_out(full_out), .empty_out(empty_out)
`ifdef SFL_DROP_EN
    , .drop_cnt(drop_cnt)
`endif
  );

  always #5 clock_1MHz = ~clock_1MHz;

  // Reference tick phase: counters free-run from reset exactly as the divider definition states
  always @(posedge clock_1MHz or posedge rst) begin
    if (rst) begin
      des_cnt <= 0;
      q_cnt   <= 0;
    end else begin
      des_cnt <= (des_cnt == DES_DIV-1) ? 0 : des_cnt + 1;
      q_cnt   <= (q_cnt == Q_DIV-1) ? 0 : q_cnt + 1;
    end
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic wait_des_tick();
    int n = 0;
    while (des_cnt != DES_DIV-1 && n < 4*DES_DIV) begin @(negedge clock_1MHz); n++; end
  endtask

  task automatic send_bit(input logic b);
    wait_des_tick();
    write_in = 1'b1;
    data_in  = b;
    @(negedge clock_1MHz);
    write_in = 1'b0;
    data_in  = 1'b0;
  endtask

  task automatic wait_collect();
    int n = 0;
    while (status_out !== 1'b1 && n < 5*Q_DIV) begin @(negedge clock_1MHz); n++; end
    if (status_out !== 1'b1) check("collect_timeout", status_out, 1);
  endtask

  task automatic send_word(input logic [WIDTH-1:0] w);
    wait_collect();
    for (int i = WIDTH-1; i >= 0; i--) send_bit(w[i]);
  endtask

  task automatic qtick(input logic do_pop);
    int n = 0;
    while (q_cnt != Q_DIV-1 && n < 4*Q_DIV) begin @(negedge clock_1MHz); n++; end
    dequeue_in = do_pop;
    @(negedge clock_1MHz);
    dequeue_in = 1'b0;
  endtask

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    rst = 1'b1;
    repeat (3) @(negedge clock_1MHz);
    check("rst_status", status_out, 1);
    check("rst_ack",    word_ack,   0);
    check("rst_data",   data_out,   0);
    check("rst_len",    len_out,    0);
    check("rst_full",   full_out,   0);
    check("rst_empty",  empty_out,  1);
`ifdef SFL_DROP_EN
    check("rst_drop",   drop_cnt,   0);
`endif
    rst = 1'b0;

    // Basic word 1,0,1,0,0,1,0,1
    send_word(8'hA5);
    check("a5_status_hold", status_out, 0);
    qtick(1'b0);
    check("a5_ack",   word_ack,  1);
    check("a5_len",   len_out,   1);
    check("a5_empty", empty_out, 0);
    @(negedge clock_1MHz);
    check("a5_ack_pulse", word_ack, 0);

    // Same word with three idle ticks mid-word
    wait_collect();
    send_bit(1); send_bit(0); send_bit(1); send_bit(0);
    for (int k = 0; k < 3; k++) begin
      wait_des_tick();
      data_in = 1'b1;
      @(negedge clock_1MHz);
      data_in = 1'b0;
    end
    send_bit(0); send_bit(1); send_bit(0);
    check("gap_still_collect", status_out, 1);
    send_bit(1);
    check("gap_hold", status_out, 0);
    qtick(1'b0);
    check("gap_len", len_out, 2);
    qtick(1'b1);
    check("pop1_data", data_out, 8'hA5);
    check("pop1_len",  len_out,  1);
    qtick(1'b1);
    check("pop2_data",  data_out,  8'hA5);
    check("pop2_empty", empty_out, 1);
    qtick(1'b1);
    check("pop_empty_data", data_out, 8'hA5);
    check("pop_empty_len",  len_out,  0);

    // Fill with 01..08 then drain in order
    for (int i = 1; i <= 8; i++) begin
      send_word(WIDTH'(i));
      qtick(1'b0);
    end
    check("fill_len",  len_out,   8);
    check("fill_full", full_out,  1);
    for (int i = 1; i <= 8; i++) begin
      qtick(1'b1);
      check($sformatf("drain_%0d", i), data_out, i);
    end
    check("drain_empty", empty_out, 1);
    check("drain_full",  full_out,  0);
    check("drain_len",   len_out,   0);

    // Full queue, ninth word with no pop, then simultaneous push and pop
    for (int i = 8'h11; i <= 8'h18; i++) begin
      send_word(WIDTH'(i));
      qtick(1'b0);
    end
    check("full2_len", len_out, 8);
    send_word(8'h19);
    qtick(1'b0);
    check("nopop_ack", word_ack, 0);
    check("nopop_len", len_out,  8);
`ifdef SFL_DROP_EN
    check("drop_cnt",    drop_cnt,   1);
    check("drop_status", status_out, 1);
    send_word(8'h19);
`else
    check("backpressure_status", status_out, 0);
    for (int i = 0; i < WIDTH; i++) send_bit(1'b1);
    check("hold_ignores_bits", status_out, 0);
`endif
    qtick(1'b1);
    check("pushpop_data", data_out, 8'h11);
    check("pushpop_len",  len_out,  8);
    check("pushpop_full", full_out, 1);
    check("pushpop_ack",  word_ack, 1);
    for (int i = 8'h12; i <= 8'h19; i++) begin
      qtick(1'b1);
      check($sformatf("wrap_%0h", i), data_out, i);
    end
    check("wrap_empty", empty_out, 1);

    // Reset mid-word discards the partial word
    wait_collect();
    send_bit(1); send_bit(1); send_bit(1); send_bit(1);
    #2 rst = 1'b1;
    #1;
    check("midrst_status", status_out, 1);
    check("midrst_data",   data_out,   0);
    check("midrst_len",    len_out,    0);
    check("midrst_empty",  empty_out,  1);
    check("midrst_full",   full_out,   0);
    check("midrst_ack",    word_ack,   0);
    @(negedge clock_1MHz);
    rst = 1'b0;
    send_word(8'hC3);
    qtick(1'b0);
    check("post_rst_len", len_out, 1);
    qtick(1'b1);
    check("post_rst_word", data_out, 8'hC3);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
